// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: assembles ALU frames from received bytes, strobes the ALU,
// and returns the 16-bit result as two bytes (low first) to the transmit path.
module alu_cmd_ctrl #(
  parameter int                  DATA_WIDTH = 8,
  parameter int                  FUN_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] OP_ALU     = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] OP_ALU_NOP = 8'hDD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     rxData,
  input  logic                      rxValid,
  output logic [DATA_WIDTH-1:0]     aluA,
  output logic [DATA_WIDTH-1:0]     aluB,
  output logic [FUN_WIDTH-1:0]      aluFunc,
  output logic                      aluEn,
  input  logic [2*DATA_WIDTH-1:0]   aluResult,
  input  logic                      aluValid,
  output logic [DATA_WIDTH-1:0]     txData,
  output logic                      txValid,
  input  logic                      txReady,
  output logic                      busy,
  output logic                      cmdErr,
  output logic                      rxDrop
);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND_LO, SEND_HI
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     aluA_q, aluA_d, aluB_q, aluB_d;
  logic [FUN_WIDTH-1:0]      aluFunc_q, aluFunc_d;
  logic                      aluEn_q, aluEn_d;
  logic [2*DATA_WIDTH-1:0]   result_q, result_d;
  logic [DATA_WIDTH-1:0]     txData_q, txData_d;
  logic                      txValid_q, txValid_d;
  logic                      busy_q, busy_d;
  logic                      cmdErr_q, cmdErr_d;
  logic                      rxDrop_q, rxDrop_d;

  always_comb begin
    state_d   = state_q;
    aluA_d    = aluA_q;
    aluB_d    = aluB_q;
    aluFunc_d = aluFunc_q;
    aluEn_d   = 1'b0;
    result_d  = result_q;
    txData_d  = txData_q;
    txValid_d = txValid_q;
    cmdErr_d  = 1'b0;
    rxDrop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxValid) begin
          if (rxData == OP_ALU)          state_d = GET_A;
          else if (rxData == OP_ALU_NOP) state_d = GET_FUN;
          else                           cmdErr_d = 1'b1;
        end
      end
      GET_A: begin
        if (rxValid) begin
          aluA_d  = rxData;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (rxValid) begin
          aluB_d  = rxData;
          state_d = GET_FUN;
        end
      end
      GET_FUN: begin
        // Upper nibble must be clear; a bad function byte aborts but keeps latched operands.
        if (rxValid) begin
          if (rxData[DATA_WIDTH-1:FUN_WIDTH] == '0) begin
            aluFunc_d = rxData[FUN_WIDTH-1:0];
            aluEn_d   = 1'b1;
            state_d   = ALU_RUN;
          end else begin
            cmdErr_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      ALU_RUN: begin
        rxDrop_d = rxValid;
        state_d  = WAIT_RES;
      end
      WAIT_RES: begin
        rxDrop_d = rxValid;
        if (aluValid) begin
          result_d  = aluResult;
          txData_d  = aluResult[DATA_WIDTH-1:0];
          txValid_d = 1'b1;
          state_d   = SEND_LO;
        end
      end
      SEND_LO: begin
        rxDrop_d = rxValid;
        if (txReady) begin
          txData_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d  = SEND_HI;
        end
      end
      SEND_HI: begin
        rxDrop_d = rxValid;
        if (txReady) begin
          txValid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aluA_q    <= '0;
      aluB_q    <= '0;
      aluFunc_q <= '0;
      aluEn_q   <= 1'b0;
      result_q  <= '0;
      txData_q  <= '0;
      txValid_q <= 1'b0;
      busy_q    <= 1'b0;
      cmdErr_q  <= 1'b0;
      rxDrop_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aluA_q    <= aluA_d;
      aluB_q    <= aluB_d;
      aluFunc_q <= aluFunc_d;
      aluEn_q   <= aluEn_d;
      result_q  <= result_d;
      txData_q  <= txData_d;
      txValid_q <= txValid_d;
      busy_q    <= busy_d;
      cmdErr_q  <= cmdErr_d;
      rxDrop_q  <= rxDrop_d;
    end
  end

  assign aluA    = aluA_q;
  assign aluB    = aluB_q;
  assign aluFunc = aluFunc_q;
  assign aluEn   = aluEn_q;
  assign txData  = txData_q;
  assign txValid = txValid_q;
  assign busy    = busy_q;
  assign cmdErr  = cmdErr_q;
  assign rxDrop  = rxDrop_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl: directed frames push expected ALU commands and tx bytes;
// a negedge monitor pops and compares on every aluEn strobe and every tx handshake.
module tb_alu_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxValid;
  logic [7:0]  aluA, aluB;
  logic [3:0]  aluFunc;
  logic        aluEn;
  logic [15:0] aluResult;
  logic        aluValid;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        busy, cmdErr, rxDrop;

  int nChecks = 0;
  int nErrors = 0;
  int enCount = 0;
  int errCount = 0;
  int dropCount = 0;
  logic [19:0] expCmd[$];
  logic [7:0]  expTx[$];
  logic [19:0] expC;
  logic [7:0]  expB;

  alu_cmd_ctrl dut (
    .clk(clk), .rst(rst), .rxData(rxData), .rxValid(rxValid),
    .aluA(aluA), .aluB(aluB), .aluFunc(aluFunc), .aluEn(aluEn),
    .aluResult(aluResult), .aluValid(aluValid),
    .txData(txData), .txValid(txValid), .txReady(txReady),
    .busy(busy), .cmdErr(cmdErr), .rxDrop(rxDrop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every ALU strobe and every accepted tx byte is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (aluEn) begin
        enCount++;
        if (expCmd.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("[TB] FAIL aluEnUnexpected: actual strobe A=%0h B=%0h F=%0h required none", aluA, aluB, aluFunc);
        end else begin
          expC = expCmd.pop_front();
          checkOutput("aluCmd", {12'h0, aluA, aluB, aluFunc}, {12'h0, expC});
        end
      end
      if (txValid && txReady) begin
        if (expTx.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("[TB] FAIL txUnexpected: actual byte %0h required none", txData);
        end else begin
          expB = expTx.pop_front();
          checkOutput("txByte", {24'h0, txData}, {24'h0, expB});
        end
      end
      if (cmdErr) errCount++;
      if (rxDrop) dropCount++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    tick();
    rxValid = 1'b0;
  endtask

  task automatic waitAluEn(input int target);
    int n = 0;
    while (enCount < target && n < 100) begin
      tick();
      n++;
    end
    checkOutput("aluEnCount", enCount, target);
  endtask

  task automatic returnResult(input logic [15:0] r);
    aluResult = r;
    aluValid  = 1'b1;
    tick();
    aluValid  = 1'b0;
  endtask

  task automatic waitTxDone();
    int n = 0;
    while (expTx.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("txDrained", expTx.size(), 0);
    checkOutput("busyAfterTx", {31'h0, busy}, 0);
  endtask

  task automatic checkReset();
    checkOutput("rstAluA", {24'h0, aluA}, 0);
    checkOutput("rstAluB", {24'h0, aluB}, 0);
    checkOutput("rstAluFunc", {28'h0, aluFunc}, 0);
    checkOutput("rstAluEn", {31'h0, aluEn}, 0);
    checkOutput("rstTxData", {24'h0, txData}, 0);
    checkOutput("rstTxValid", {31'h0, txValid}, 0);
    checkOutput("rstBusy", {31'h0, busy}, 0);
    checkOutput("rstCmdErr", {31'h0, cmdErr}, 0);
    checkOutput("rstRxDrop", {31'h0, rxDrop}, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, d0;
    rst = 1'b1; rxData = 8'h00; rxValid = 1'b0;
    aluResult = 16'h0; aluValid = 1'b0; txReady = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checkReset();

    // Full frame, minimum turnaround on both sides.
    expCmd.push_back({8'h12, 8'h34, 4'h0});
    expTx.push_back(8'h46); expTx.push_back(8'h00);
    applyStimulus(8'hCC); applyStimulus(8'h12); applyStimulus(8'h34); applyStimulus(8'h00);
    checkOutput("aluEnLatency", {31'h0, aluEn}, 1);
    waitAluEn(1);
    returnResult(16'h0046);
    checkOutput("txValidLatency", {31'h0, txValid}, 1);
    waitTxDone();

    // NOP frame reuses stored operands; transmitter stalls in SEND_LO.
    expCmd.push_back({8'h12, 8'h34, 4'h5});
    expTx.push_back(8'hCD); expTx.push_back(8'hAB);
    txReady = 1'b0;
    applyStimulus(8'hDD); applyStimulus(8'h05);
    waitAluEn(2);
    returnResult(16'hABCD);
    for (int i = 0; i < 10; i++) begin
      checkOutput("holdTxValid", {31'h0, txValid}, 1);
      checkOutput("holdTxData", {24'h0, txData}, 32'hCD);
      tick();
    end
    txReady = 1'b1;
    waitTxDone();

    // Bad opcode, then bad function byte.
    e0 = errCount;
    applyStimulus(8'h7E);
    tick();
    checkOutput("cmdErrOpcode", errCount, e0 + 1);
    checkOutput("busyAfterBadOp", {31'h0, busy}, 0);
    applyStimulus(8'hCC); applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'hF3);
    tick();
    checkOutput("cmdErrFunc", errCount, e0 + 2);
    checkOutput("noAluEnBadFunc", enCount, 2);
    checkOutput("busyAfterBadFunc", {31'h0, busy}, 0);
    checkOutput("keptAluA", {24'h0, aluA}, 32'h01);
    checkOutput("keptAluB", {24'h0, aluB}, 32'h02);
    checkOutput("keptAluFunc", {28'h0, aluFunc}, 32'h5);

    // Byte arriving during WAIT_RES is dropped.
    expCmd.push_back({8'h01, 8'h02, 4'h6});
    expTx.push_back(8'h34); expTx.push_back(8'h12);
    applyStimulus(8'hDD); applyStimulus(8'h06);
    waitAluEn(3);
    d0 = dropCount;
    applyStimulus(8'h55);
    tick();
    checkOutput("rxDropPulse", dropCount, d0 + 1);
    returnResult(16'h1234);
    waitTxDone();

    // Reset in GET_B, then a NOP frame sees cleared operands.
    applyStimulus(8'hCC); applyStimulus(8'h11);
    rst = 1'b1;
    tick();
    checkReset();
    rst = 1'b0;
    expCmd.push_back({8'h00, 8'h00, 4'h3});
    expTx.push_back(8'hFF); expTx.push_back(8'h00);
    applyStimulus(8'hDD); applyStimulus(8'h03);
    waitAluEn(4);
    returnResult(16'h00FF);
    waitTxDone();

    // Reset while the high byte is pending.
    expCmd.push_back({8'hAA, 8'h55, 4'hF});
    expTx.push_back(8'hA5); expTx.push_back(8'h5A);
    txReady = 1'b0;
    applyStimulus(8'hCC); applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'h0F);
    waitAluEn(5);
    returnResult(16'h5AA5);
    txReady = 1'b1;
    tick();
    txReady = 1'b0;
    checkOutput("sendHiData", {24'h0, txData}, 32'h5A);
    checkOutput("sendHiValid", {31'h0, txValid}, 1);
    rst = 1'b1;
    tick();
    checkReset();
    rst = 1'b0;
    expTx.delete();
    txReady = 1'b1;
    tick();
    checkOutput("noResendAfterRst", {31'h0, txValid}, 0);

    expCmd.push_back({8'h3C, 8'hC3, 4'h9});
    expTx.push_back(8'h78); expTx.push_back(8'h56);
    applyStimulus(8'hCC); applyStimulus(8'h3C); applyStimulus(8'hC3); applyStimulus(8'h09);
    waitAluEn(6);
    returnResult(16'h5678);
    waitTxDone();

    checkOutput("cmdQueueEmpty", expCmd.size(), 0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command-side controller for the ALU. It takes a byte stream from the serial receive path and assembles ALU command frames. It drives the ALU function code (aluFunc[3:2] selects the arith/logic/cmp/shift unit, aluFunc[1:0] selects the operation within it), operands and a one-cycle enable. It then captures the 16-bit ALU result and returns it as two bytes to the serial transmit path.

Parameters:
DATA_WIDTH, 8, operand and byte width
FUN_WIDTH, 4, ALU function code width
OP_ALU, 8'hCC, opcode: frame carries A, B, function
OP_ALU_NOP, 8'hDD, opcode: frame carries function only; reuse stored A/B

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
rxData  in  8  received byte
rxValid  in  1  one-cycle strobe, rxData valid
aluA  out  8  operand A register
aluB  out  8  operand B register
aluFunc  out  4  ALU function code
aluEn  out  1  one-cycle ALU start strobe
aluResult  in  16  ALU result
aluValid  in  1  one-cycle strobe, aluResult valid
txData  out  8  byte to transmit
txValid  out  1  txData valid; held until accepted
txReady  in  1  transmitter accepts on txValid && txReady
busy  out  1  high in every state except IDLE
cmdErr  out  1  one-cycle pulse on a bad opcode or bad function byte
rxDrop  out  1  one-cycle pulse when rxValid arrives in a non-receiving state

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; aluA, aluB, aluFunc, txData, result register = 0; aluEn, txValid, busy, cmdErr, rxDrop = 0. Reset takes priority over every other event, including mid-frame and mid-transmit. A frame interrupted by reset is discarded, and no partial byte is re-sent.
- States: IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND_LO, SEND_HI.
- IDLE:
  - rxValid with rxData==OP_ALU -> GET_A.
  - rxValid with rxData==OP_ALU_NOP -> GET_FUN.
  - Any other byte -> cmdErr pulse next cycle; stay IDLE.
- GET_A: on rxValid, latch aluA -> GET_B.
- GET_B: on rxValid, latch aluB -> GET_FUN.
- GET_FUN: on rxValid:
  - rxData[7:4]==0: latch aluFunc=rxData[3:0] -> ALU_RUN.
  - Otherwise: cmdErr pulse; aluFunc unchanged -> IDLE. aluA/aluB keep any bytes already latched.
- Receiving states wait indefinitely; there is no inter-byte timeout.
- ALU_RUN: aluEn=1 for exactly this one cycle; aluA/aluB/aluFunc are stable -> WAIT_RES.
- aluA, aluB, aluFunc are registered outputs and hold their value until next overwritten or reset.
- WAIT_RES: on aluValid, capture aluResult -> SEND_LO. An aluValid seen in any other state is ignored.
- SEND_LO: txValid=1, txData=result[7:0]. When txValid&&txReady at an edge -> SEND_HI, with txValid still 1 and txData=result[15:8].
- SEND_HI: on txValid&&txReady -> IDLE, txValid=0.
- txData must not change while txValid=1 and txReady=0.
- Minimum turnaround: a frame's final byte at cycle N gives aluEn at N+1. aluValid at cycle M gives txValid at M+1.
- rxValid in ALU_RUN, WAIT_RES, SEND_LO or SEND_HI: byte dropped, rxDrop pulse next cycle, state unaffected.
- Stored operands persist across frames; OP_ALU_NOP after reset uses A=B=0.
- cmdErr and rxDrop are registered, asserted the cycle after the triggering rxValid, and last one cycle.

Test Plan:
- Reset, then bytes CC,12,34,00 -> aluA=12, aluB=34, aluFunc=0, one aluEn pulse. Return aluResult=0046 -> tx bytes 46 then 00; busy falls after 2nd accept.
- After the above, send DD,05; return aluResult=ABCD -> aluEn once with aluA=12, aluB=34, aluFunc=5; tx bytes CD then AB.
- Hold txReady=0 for 10 cycles in SEND_LO -> txValid=1 and txData=CD stable throughout; accept on release.
- Byte 7E in IDLE -> cmdErr pulse, state IDLE. Send CC,01,02,F3 -> cmdErr, no aluEn, IDLE.
- rxValid 55 during WAIT_RES -> rxDrop pulse; result still sent correctly.
- Assert rst in GET_B, then separately in SEND_HI -> next cycle all outputs 0 and state IDLE. A following CC,… frame works normally.
